// File: rtl/logic_gate_unit.sv
// Two-stage pipelined N-operand bitwise gate with valid/ready handshakes on both
// sides and a saturating count of completed output transfers.
module logic_gate_unit #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned N_IN    = 2,
  parameter int unsigned COUNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_mode,
  input  logic [N_IN*WIDTH-1:0]   in_ops,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_result,
  output logic                    out_err,
  output logic [COUNT_W-1:0]      xfer_count
);

  localparam logic [2:0] MODE_AND  = 3'd0;
  localparam logic [2:0] MODE_OR   = 3'd1;
  localparam logic [2:0] MODE_XOR  = 3'd2;
  localparam logic [2:0] MODE_NAND = 3'd3;
  localparam logic [2:0] MODE_NOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;
  localparam logic [2:0] MODE_PASS = 3'd6;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  // Returns {err, result}; inverted modes invert the full N_IN-wide reduction.
  function automatic logic [WIDTH:0] reduce_ops(input logic [2:0] mode,
                                                input logic [N_IN*WIDTH-1:0] ops);
    logic [WIDTH-1:0] and_v;
    logic [WIDTH-1:0] or_v;
    logic [WIDTH-1:0] xor_v;
    logic [WIDTH-1:0] res;
    logic             err;
    and_v = {WIDTH{1'b1}};
    or_v  = {WIDTH{1'b0}};
    xor_v = {WIDTH{1'b0}};
    for (int k = 0; k < int'(N_IN); k++) begin
      and_v = and_v & ops[k*WIDTH +: WIDTH];
      or_v  = or_v  | ops[k*WIDTH +: WIDTH];
      xor_v = xor_v ^ ops[k*WIDTH +: WIDTH];
    end
    err = 1'b0;
    case (mode)
      MODE_AND:  res = and_v;
      MODE_OR:   res = or_v;
      MODE_XOR:  res = xor_v;
      MODE_NAND: res = ~and_v;
      MODE_NOR:  res = ~or_v;
      MODE_XNOR: res = ~xor_v;
      MODE_PASS: res = ops[WIDTH-1:0];
      default: begin
        res = {WIDTH{1'b0}};
        err = 1'b1;
      end
    endcase
    return {err, res};
  endfunction

  logic                  s1_valid_q, s1_valid_d;
  logic [2:0]            s1_mode_q,  s1_mode_d;
  logic [N_IN*WIDTH-1:0] s1_ops_q,   s1_ops_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_result_q, out_result_d;
  logic                  out_err_q, out_err_d;
  logic [COUNT_W-1:0]    count_q, count_d;

  logic                  stage2_adv_s;
  logic                  stage1_adv_s;
  logic [WIDTH:0]        red_s;

  assign stage2_adv_s = !out_valid_q || out_ready;
  assign stage1_adv_s = !s1_valid_q || stage2_adv_s;
  assign red_s        = reduce_ops(s1_mode_q, s1_ops_q);

  // Next-state for both pipeline stages and the transfer counter.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_mode_d    = s1_mode_q;
    s1_ops_d     = s1_ops_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    count_d      = count_q;

    if (stage1_adv_s) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // Operands are captured only on an input handshake.
    if (stage1_adv_s && in_valid) begin
      s1_mode_d = in_mode;
      s1_ops_d  = in_ops;
    end else begin
      s1_mode_d = s1_mode_q;
      s1_ops_d  = s1_ops_q;
    end

    if (stage2_adv_s) begin
      out_valid_d = s1_valid_q;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (stage2_adv_s && s1_valid_q) begin
      out_result_d = red_s[WIDTH-1:0];
      out_err_d    = red_s[WIDTH];
    end else begin
      out_result_d = out_result_q;
      out_err_d    = out_err_q;
    end

    if (out_valid_q && out_ready && (count_q != COUNT_MAX)) begin
      count_d = count_q + COUNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= 3'd0;
      s1_ops_q     <= {(N_IN*WIDTH){1'b0}};
      out_valid_q  <= 1'b0;
      out_result_q <= {WIDTH{1'b0}};
      out_err_q    <= 1'b0;
      count_q      <= {COUNT_W{1'b0}};
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_ops_q     <= s1_ops_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
      count_q      <= count_d;
    end
  end

  assign in_ready   = stage1_adv_s;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;
  assign xfer_count = count_q;

endmodule
